// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer beside the E-stage ALU.
// Fixed-latency busy period, then commits the precomputed result to HI/LO.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  output logic [31:0] md_rdata,
  output logic        busy,
  output logic        md_start,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           busy_q;
  logic [31:0]    hi_q;
  logic [31:0]    lo_q;
  logic [31:0]    res_hi_q;
  logic [31:0]    res_lo_q;
  logic           res_wr_q;
  logic [31:0]    res_hi_d;
  logic [31:0]    res_lo_d;
  logic           res_wr_d;

  logic [63:0]        sprod;
  logic [63:0]        uprod;
  logic signed [32:0] sa;
  logic signed [32:0] sb;
  logic signed [32:0] sq;
  logic signed [32:0] sr;
  logic [31:0]        ud;
  logic [31:0]        uq;
  logic [31:0]        ur;

  assign md_start = e_valid & (e_md_op >= OP_MULT) &
                    (e_md_op <= OP_DIVU);
  assign md_stall = d_is_md & (md_start | busy_q);
  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // 33-bit signed divide keeps 0x80000000 / -1 from overflowing;
  // a zero divisor is swapped for 1 and the commit is suppressed.
  assign sprod = $signed({{32{e_rs[31]}}, e_rs}) *
                 $signed({{32{e_rt[31]}}, e_rt});
  assign uprod = {32'b0, e_rs} * {32'b0, e_rt};
  assign sa    = $signed({e_rs[31], e_rs});
  assign sb    = (e_rt == 32'd0) ? 33'sd1 :
                 $signed({e_rt[31], e_rt});
  assign sq    = sa / sb;
  assign sr    = sa % sb;
  assign ud    = (e_rt == 32'd0) ? 32'd1 : e_rt;
  assign uq    = e_rs / ud;
  assign ur    = e_rs % ud;

  always_comb begin
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    res_wr_d = 1'b1;
    cnt_d    = CW'(MULT_CYCLES);
    case (e_md_op)
      OP_MULT:  {res_hi_d, res_lo_d} = sprod;
      OP_MULTU: {res_hi_d, res_lo_d} = uprod;
      OP_DIV: begin
        res_lo_d = sq[31:0];
        res_hi_d = sr[31:0];
        res_wr_d = |e_rt;
        cnt_d    = CW'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_lo_d = uq;
        res_hi_d = ur;
        res_wr_d = |e_rt;
        cnt_d    = CW'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  always_comb begin
    md_rdata = 32'd0;
    case (e_md_op)
      OP_MFHI: md_rdata = hi_q;
      OP_MFLO: md_rdata = lo_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
          end else if (e_valid && e_md_op == OP_MTHI) begin
            hi_q <= e_rs;
          end else if (e_valid && e_md_op == OP_MTLO) begin
            lo_q <= e_rs;
          end
        end
        RUN: begin
          // Starts and HI/LO writes arriving while busy are dropped.
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (res_wr_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed vectors, stall/abort scenarios
// and randomized ops against an arithmetic HI/LO reference model.
module tb_md_sequencer;

  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5;
  localparam logic [3:0] MFLO  = 4'd6;
  localparam logic [3:0] MTHI  = 4'd7;
  localparam logic [3:0] MTLO  = 4'd8;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_is_md;
  logic [31:0] md_rdata;
  logic        busy;
  logic        md_start;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid),
    .e_md_op(e_md_op), .e_rs(e_rs), .e_rt(e_rt),
    .d_is_md(d_is_md), .md_rdata(md_rdata), .busy(busy),
    .md_start(md_start), .md_stall(md_stall),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_cycles(input logic [3:0] op);
    return (op == DIV || op == DIVU) ? 10 : 5;
  endfunction

  function automatic void model_apply(input logic [3:0] op,
                                      input logic [31:0] rs,
                                      input logic [31:0] rt);
    longint a, b, q, r;
    longint unsigned up;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    case (op)
      MULT: begin
        q = a * b;
        m_hi = q[63:32];
        m_lo = q[31:0];
      end
      MULTU: begin
        up = {32'b0, rs} * {32'b0, rt};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      DIV: if (rt != 0) begin
        q = a / b;
        r = a % b;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      DIVU: if (rt != 0) begin
        m_lo = rs / rt;
        m_hi = rs % rt;
      end
      MTHI: m_hi = rs;
      MTLO: m_lo = rs;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] rs,
                        input logic [31:0] rt,
                        output logic st,
                        output int cyc);
    e_valid = 1'b1;
    e_md_op = op;
    e_rs = rs;
    e_rt = rt;
    #1;
    st = md_start;
    tick();
    e_valid = 1'b0;
    e_md_op = 4'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      cyc++;
      tick();
    end
  endtask

  task automatic write_hilo(input logic [3:0] op,
                            input logic [31:0] v);
    e_valid = 1'b1;
    e_md_op = op;
    e_rs = v;
    tick();
    e_valid = 1'b0;
    e_md_op = 4'd0;
    model_apply(op, v, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h want 0/0/0",
               busy, hi, lo);
    end
    reset = 1'b0;
    e_md_op = MFHI;
    d_is_md = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || md_stall !== 1'b0 || md_start !== 1'b0 ||
        md_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b stall=%b start=%b rd=%h want 0",
               busy, md_stall, md_start, md_rdata);
    end
    e_md_op = 4'd0;
    d_is_md = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_directed();
    logic [3:0]  op [5];
    logic [31:0] rs [5];
    logic [31:0] rt [5];
    logic [31:0] eh [5];
    logic [31:0] el [5];
    int          ec [5];
    logic st;
    int cyc;
    op = '{MULT, MULTU, DIV, DIV, DIVU};
    rs = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFF9,
           32'h80000000, 32'h0};
    rt = '{32'hFFFFFFFE, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0};
    eh = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h12345678};
    el = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFD,
           32'h80000000, 32'h12345678};
    ec = '{5, 5, 10, 10, 10};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        write_hilo(MTHI, 32'h12345678);
        write_hilo(MTLO, 32'h12345678);
      end
      run_op(op[i], rs[i], rt[i], st, cyc);
      model_apply(op[i], rs[i], rt[i]);
      n_checks++;
      if (st !== 1'b1 || cyc != ec[i] || hi !== eh[i] ||
          lo !== el[i]) begin
        n_fail++;
        $display("FAIL directed_%0d start=%b cyc=%0d hi=%h lo=%h want 1/%0d/%h/%h",
                 i, st, cyc, hi, lo, ec[i], eh[i], el[i]);
      end
    end
  endtask

  task automatic test_stall();
    int stalls;
    int k;
    d_is_md = 1'b1;
    e_valid = 1'b1;
    e_md_op = MULT;
    e_rs = 32'd7;
    e_rt = 32'd6;
    #1;
    n_checks++;
    if (md_start !== 1'b1 || md_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_start start=%b stall=%b want 1/1",
               md_start, md_stall);
    end
    stalls = (md_stall === 1'b1) ? 1 : 0;
    tick();
    e_valid = 1'b0;
    e_md_op = 4'd0;
    k = 0;
    while (busy === 1'b1 && k < 50) begin
      if (md_stall === 1'b1) stalls++;
      k++;
      tick();
    end
    model_apply(MULT, 32'd7, 32'd6);
    e_valid = 1'b1;
    e_md_op = MFLO;
    #1;
    n_checks++;
    if (stalls != 6 || md_stall !== 1'b0 ||
        md_rdata !== 32'd42) begin
      n_fail++;
      $display("FAIL stall_window stalls=%0d stall=%b rd=%h want 6/0/%h",
               stalls, md_stall, md_rdata, 32'd42);
    end
    tick();
    e_valid = 1'b0;
    e_md_op = 4'd0;
    d_is_md = 1'b0;
  endtask

  task automatic test_ignored_start();
    int cyc;
    e_valid = 1'b1;
    e_md_op = MULT;
    e_rs = 32'h10;
    e_rt = 32'h10;
    tick();
    e_valid = 1'b0;
    e_md_op = 4'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      cyc++;
      e_valid = (cyc == 1 || cyc == 2);
      e_md_op = (cyc == 1) ? DIV : (cyc == 2) ? MTHI : 4'd0;
      e_rs = (cyc == 1) ? 32'd100 : 32'hDEAD;
      e_rt = 32'd3;
      tick();
    end
    e_valid = 1'b0;
    e_md_op = 4'd0;
    model_apply(MULT, 32'h10, 32'h10);
    n_checks++;
    if (cyc != 5 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL ignored_start cyc=%0d hi=%h lo=%h want 5/%h/%h",
               cyc, hi, lo, m_hi, m_lo);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_queued busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic st;
    int cyc;
    run_op(MULT, 32'hFFFF0000, 32'h00010001, st, cyc);
    model_apply(MULT, 32'hFFFF0000, 32'h00010001);
    n_checks++;
    if (cyc != 5 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL b2b_first cyc=%0d hi=%h lo=%h want 5/%h/%h",
               cyc, hi, lo, m_hi, m_lo);
    end
    run_op(DIVU, 32'd1000, 32'd7, st, cyc);
    model_apply(DIVU, 32'd1000, 32'd7);
    n_checks++;
    if (st !== 1'b1 || cyc != 10 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL b2b_second st=%b cyc=%0d hi=%h lo=%h want 1/10/%h/%h",
               st, cyc, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_abort();
    write_hilo(MTHI, 32'h11);
    write_hilo(MTLO, 32'h22);
    e_valid = 1'b1;
    e_md_op = DIV;
    e_rs = 32'd100;
    e_rt = 32'd7;
    tick();
    e_valid = 1'b0;
    e_md_op = 4'd0;
    tick();
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy4 busy=%b want 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_reset busy=%b hi=%h lo=%h want 0/0/0",
               busy, hi, lo);
    end
    repeat (12) tick();
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_nocommit busy=%b hi=%h lo=%h want 0/0/0",
               busy, hi, lo);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
    write_hilo(MTLO, 32'hA5);
    n_checks++;
    if (lo !== 32'hA5 || hi !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_mtlo hi=%h lo=%h want 0/a5", hi, lo);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        st;
    int          cyc;
    int          sel;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 11));
      rs = $urandom;
      rt = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rt = 32'd0;
      if (sel == 1) rt = 32'hFFFFFFFF;
      if (sel == 2) rs = 32'h80000000;
      if (sel == 3) rt = 32'($urandom_range(1, 9));
      if (op >= MULT && op <= DIVU) begin
        run_op(op, rs, rt, st, cyc);
        model_apply(op, rs, rt);
        n_checks++;
        if (st !== 1'b1 || cyc != exp_cycles(op) ||
            hi !== m_hi || lo !== m_lo) begin
          n_fail++;
          $display("FAIL rand_arith op=%0d rs=%h rt=%h st=%b cyc=%0d hi=%h lo=%h want %0d/%h/%h",
                   op, rs, rt, st, cyc, hi, lo,
                   exp_cycles(op), m_hi, m_lo);
        end
      end else if (op == MFHI || op == MFLO) begin
        e_valid = 1'b1;
        e_md_op = op;
        #1;
        n_checks++;
        if (md_rdata !== ((op == MFHI) ? m_hi : m_lo)) begin
          n_fail++;
          $display("FAIL rand_mf op=%0d rd=%h want %h", op, md_rdata,
                   (op == MFHI) ? m_hi : m_lo);
        end
        tick();
        e_valid = 1'b0;
        e_md_op = 4'd0;
      end else begin
        e_valid = (op == MTHI || op == MTLO) ? sel[0] : 1'b1;
        e_md_op = op;
        e_rs = rs;
        #1;
        st = md_start;
        tick();
        if (e_valid) model_apply(op, rs, rt);
        e_valid = 1'b0;
        e_md_op = 4'd0;
        n_checks++;
        if (st !== 1'b0 || busy !== 1'b0 ||
            hi !== m_hi || lo !== m_lo) begin
          n_fail++;
          $display("FAIL rand_misc op=%0d st=%b busy=%b hi=%h lo=%h want 0/0/%h/%h",
                   op, st, busy, hi, lo, m_hi, m_lo);
        end
      end
    end
    e_valid = 1'b0;
    e_md_op = MULT;
    #1;
    n_checks++;
    if (md_start !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_start start=%b want 0", md_start);
    end
    e_md_op = 4'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    e_valid = 1'b0;
    e_md_op = 4'd0;
    e_rs = 32'd0;
    e_rt = 32'd0;
    d_is_md = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    test_reset();
    test_directed();
    test_stall();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
